sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, number of ACCESS-state cycles per transaction (legal 1..15).
REQ-002 SHALL have port CLK  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RSTX  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports REQ0/REQ1  in  1  transaction request from port 0 (CPU) / port 1 (DMA).
REQ-005 SHALL have ports WE0/WE1  in  1  1 = write, 0 = read; valid while REQn high.
REQ-006 SHALL have ports ADDR0/ADDR1  in  18  word address; valid while REQn high.
REQ-007 SHALL have ports DIN0/DIN1  in  16  write data; valid while REQn high.
REQ-008 SHALL have ports ACK0/ACK1  out  1  one-cycle completion pulse, registered.
REQ-009 SHALL have ports DOUT0/DOUT1  out  16  last read data returned to that port, registered.
REQ-010 SHALL have port SRAM_ADDR  out  18  SRAM address, registered.
REQ-011 SHALL have port SRAM_DO  out  16  SRAM write data, registered.
REQ-012 SHALL have port SRAM_DI  in  16  SRAM read data from top-level tristate.
REQ-013 SHALL have port SRAM_DOE  out  1  tristate drive enable for SRAM_DATA, registered.
REQ-014 SHALL have ports SRAM_WEX/SRAM_OEX/SRAM_CSX  out  1  active-low write/output/chip enables, registered.

Function
REQ-015 SHALL implement states IDLE, SETUP, ACCESS, DONE.
REQ-016 IDLE: CSX=OEX=WEX=1, DOE=0; if any REQn high at edge, latch winner's ADDR/WE/DIN, go SETUP; else stay.
REQ-017 SETUP (1 cycle): CSX=0, SRAM_ADDR=latched addr; read: OEX=0; write: DOE=1, SRAM_DO=latched data, WEX=1.
REQ-018 ACCESS (WAIT_CYCLES cycles, 4-bit down-counter): read: OEX=0; write: WEX=0, DOE=1.
REQ-019 Read: SRAM_DI SHALL be captured into DOUTn of granted port at the edge leaving last ACCESS cycle.
REQ-020 DONE (1 cycle): WEX=1, OEX=1; write keeps CSX=0, DOE=1, address/data held (hold time); ACKn=1 for granted port only; next state IDLE.
REQ-021 Latency: REQ sampled at edge k -> ACK high in cycle k+2+WAIT_CYCLES; back-to-back throughput one transaction per 3+WAIT_CYCLES cycles.
REQ-022 Requester SHALL hold REQ/WE/ADDR/DIN until ACK; inputs changing after grant SHALL NOT affect the active transaction.
REQ-023 REQn still high in IDLE after its ACK SHALL be treated as a new request.
REQ-024 SRAM_DOE=1 and SRAM_OEX=0 SHALL never be asserted in the same cycle.
REQ-025 DOUTn SHALL change only on a read completing for port n; writes leave DOUT unchanged.
REQ-026 ACK0 and ACK1 SHALL never be high simultaneously.
REQ-027 Simultaneous REQ0 and REQ1 in IDLE: resolved per REQ-031; loser waits, REQ held, served next arbitration.

Reset
REQ-028 RSTX low SHALL immediately force state IDLE, CSX=OEX=WEX=1, DOE=0, ACK0=ACK1=0, counter 0, SRAM_ADDR=0, SRAM_DO=0.
REQ-029 DOUT0/DOUT1 SHALL reset to 0x0000; round-robin pointer resets to "port 1 last granted".
REQ-030 Reset mid-transaction SHALL abort it with no ACK; first edge after RSTX release samples REQ in IDLE.

Configuration
REQ-031 Macro SRAM_ARB_RR_EN: defined -> round-robin, grant the port not granted last on conflict; undefined -> fixed priority, port 0 always wins conflict, pointer logic absent.

Verification
REQ-032 WAIT_CYCLES=1, REQ0 write addr 0x00003 data 0xBEEF -> WEX low 1 cycle, DOE high SETUP..DONE, ACK0 at k+3.
REQ-033 Then REQ0 read addr 0x00003 -> OEX low 2 cycles, DOUT0=0xBEEF with ACK0, DOE stays 0.
REQ-034 REQ0 and REQ1 reads held continuously: fixed mode -> ACK0 every 4 cycles, ACK1 never; RR_EN -> ACK0, ACK1 alternate, first ACK0.
REQ-035 WAIT_CYCLES=3, REQ1 read 0x3FFFF returning 0x1234 -> ACK1 at k+5, DOUT1=0x1234, DOUT0 unchanged.
REQ-036 RSTX low during write ACCESS -> WEX/CSX high and DOE low same cycle, no ACK; after release, held REQ0 restarts and completes.
REQ-037 Every cycle of all runs: assert no DOE&&~OEX, no ACK0&&ACK1, CSX high in IDLE.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Request/response and SRAM pin bundle for sram_arbiter.
// slave: the arbiter side; master: requesters plus the SRAM read-data pin.
interface sram_arbiter_if;
  logic        REQ0;
  logic        REQ1;
  logic        WE0;
  logic        WE1;
  logic [17:0] ADDR0;
  logic [17:0] ADDR1;
  logic [15:0] DIN0;
  logic [15:0] DIN1;
  logic        ACK0;
  logic        ACK1;
  logic [15:0] DOUT0;
  logic [15:0] DOUT1;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DO;
  logic [15:0] SRAM_DI;
  logic        SRAM_DOE;
  logic        SRAM_WEX;
  logic        SRAM_OEX;
  logic        SRAM_CSX;

  modport slave (
    input  REQ0, REQ1, WE0, WE1,
    input  ADDR0, ADDR1, DIN0, DIN1,
    input  SRAM_DI,
    output ACK0, ACK1, DOUT0, DOUT1,
    output SRAM_ADDR, SRAM_DO, SRAM_DOE,
    output SRAM_WEX, SRAM_OEX, SRAM_CSX
  );

  modport master (
    output REQ0, REQ1, WE0, WE1,
    output ADDR0, ADDR1, DIN0, DIN1,
    output SRAM_DI,
    input  ACK0, ACK1, DOUT0, DOUT1,
    input  SRAM_ADDR, SRAM_DO, SRAM_DOE,
    input  SRAM_WEX, SRAM_OEX, SRAM_CSX
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port async-SRAM arbiter: IDLE/SETUP/ACCESS/DONE sequencer, all pins registered.
// Define SRAM_ARB_RR_EN for round-robin on conflict; default is fixed port-0 priority.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic           CLK,
  input logic           RSTX,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] do_q, do_d;
  logic        csx_q, csx_d;
  logic        oex_q, oex_d;
  logic        wex_q, wex_d;
  logic        doe_q, doe_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] dout0_q, dout0_d;
  logic [15:0] dout1_q, dout1_d;
  logic        req_any;
  logic        pick;

  assign req_any = bus.REQ0 | bus.REQ1;

`ifdef SRAM_ARB_RR_EN
  // last_q = 1 means port 1 was granted most recently
  logic last_q, last_d;

  always_comb begin
    unique case (1'b1)
      bus.REQ0 && bus.REQ1:  pick = ~last_q;
      !bus.REQ0 && bus.REQ1: pick = 1'b1;
      default:               pick = 1'b0;
    endcase
  end
`else
  assign pick = ~bus.REQ0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    do_d    = do_q;
    csx_d   = csx_q;
    oex_d   = oex_q;
    wex_d   = wex_q;
    doe_d   = doe_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
`ifdef SRAM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        csx_d = 1'b1;
        oex_d = 1'b1;
        wex_d = 1'b1;
        doe_d = 1'b0;
        if (req_any) begin
          state_d = SETUP;
          gnt_d   = pick;
          we_d    = pick ? bus.WE1 : bus.WE0;
          addr_d  = pick ? bus.ADDR1 : bus.ADDR0;
          do_d    = pick ? bus.DIN1 : bus.DIN0;
          csx_d   = 1'b0;
          oex_d   = we_d;
          doe_d   = we_d;
`ifdef SRAM_ARB_RR_EN
          last_d  = pick;
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_INIT;
        wex_d   = ~we_q;
        oex_d   = we_q;
        doe_d   = we_q;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          wex_d   = 1'b1;
          oex_d   = 1'b1;
          // writes keep CS and the data bus driven for hold time
          csx_d   = ~we_q;
          doe_d   = we_q;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          if (!we_q) begin
            if (gnt_q) dout1_d = bus.SRAM_DI;
            else       dout0_d = bus.SRAM_DI;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        csx_d   = 1'b1;
        oex_d   = 1'b1;
        wex_d   = 1'b1;
        doe_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 18'd0;
      do_q    <= 16'd0;
      csx_q   <= 1'b1;
      oex_q   <= 1'b1;
      wex_q   <= 1'b1;
      doe_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      dout0_q <= 16'd0;
      dout1_q <= 16'd0;
`ifdef SRAM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      do_q    <= do_d;
      csx_q   <= csx_d;
      oex_q   <= oex_d;
      wex_q   <= wex_d;
      doe_q   <= doe_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
`ifdef SRAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.ACK0      = ack0_q;
  assign bus.ACK1      = ack1_q;
  assign bus.DOUT0     = dout0_q;
  assign bus.DOUT1     = dout1_q;
  assign bus.SRAM_ADDR = addr_q;
  assign bus.SRAM_DO   = do_q;
  assign bus.SRAM_DOE  = doe_q;
  assign bus.SRAM_WEX  = wex_q;
  assign bus.SRAM_OEX  = oex_q;
  assign bus.SRAM_CSX  = csx_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, corner sequences, randomized traffic vs model.
// Two instances: WAIT_CYCLES=1 (main) and WAIT_CYCLES=3.
module tb_sram_arbiter;

  localparam int W1 = 1;
  localparam int W3 = 3;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_arbiter_if b1();
  sram_arbiter_if b3();

  sram_arbiter #(.WAIT_CYCLES(W1)) dut1 (
    .CLK(clk), .RSTX(rst_n), .bus(b1.slave)
  );
  sram_arbiter #(.WAIT_CYCLES(W3)) dut3 (
    .CLK(clk), .RSTX(rst_n), .bus(b3.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // behavioural SRAM: write while CS&WE low, read data presented when OE low
  logic [15:0] mem1 [int];
  logic [15:0] mem3 [int];
  always @(negedge clk) begin
    if (!b1.SRAM_CSX && !b1.SRAM_WEX)
      mem1[int'(b1.SRAM_ADDR)] = b1.SRAM_DO;
    if (!b3.SRAM_CSX && !b3.SRAM_WEX)
      mem3[int'(b3.SRAM_ADDR)] = b3.SRAM_DO;
    b1.SRAM_DI = (!b1.SRAM_OEX && mem1.exists(int'(b1.SRAM_ADDR)))
                 ? mem1[int'(b1.SRAM_ADDR)] : 16'hA5A5;
    b3.SRAM_DI = (!b3.SRAM_OEX && mem3.exists(int'(b3.SRAM_ADDR)))
                 ? mem3[int'(b3.SRAM_ADDR)] : 16'hA5A5;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("doe_oex_1", b1.SRAM_DOE & ~b1.SRAM_OEX, 0);
      chk("ack_both_1", b1.ACK0 & b1.ACK1, 0);
      chk("doe_oex_3", b3.SRAM_DOE & ~b3.SRAM_OEX, 0);
      chk("ack_both_3", b3.ACK0 & b3.ACK1, 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    b1.REQ0 = 0; b1.REQ1 = 0;
    b3.REQ0 = 0; b3.REQ1 = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit p, input bit rq, input bit we,
                       input logic [17:0] a, input logic [15:0] d);
    if (p) begin
      b1.REQ1 = rq; b1.WE1 = we; b1.ADDR1 = a; b1.DIN1 = d;
    end else begin
      b1.REQ0 = rq; b1.WE0 = we; b1.ADDR0 = a; b1.DIN0 = d;
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [17:0] addr;
    logic [15:0] din;
    logic [15:0] d0;
    logic [15:0] d1;
  } vec_t;

  vec_t tv[7];

  initial begin
    int lat, wl, ol, dh, idx;
    bit got, a0, a1;
    int e, g_e, ack_e, nf;
    bit gp, last, pend_rd;
    logic [15:0] pend_v;
    logic [15:0] ed[2];
    logic [15:0] refm[8];
    bit rq[2], rw[2];
    logic [17:0] ra[2];
    logic [15:0] r_d[2];

    tv[0] = '{1'b0, 1'b1, 18'h00003, 16'hBEEF, 16'h0000, 16'h0000};
    tv[1] = '{1'b0, 1'b0, 18'h00003, 16'h0000, 16'hBEEF, 16'h0000};
    tv[2] = '{1'b1, 1'b1, 18'h3FFFF, 16'h1234, 16'hBEEF, 16'h0000};
    tv[3] = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 16'hBEEF, 16'h1234};
    tv[4] = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 16'h1234, 16'h1234};
    tv[5] = '{1'b1, 1'b1, 18'h00003, 16'h5A5A, 16'h1234, 16'h1234};
    tv[6] = '{1'b1, 1'b0, 18'h00003, 16'h0000, 16'h1234, 16'h5A5A};

    rst_n = 1'b0;
    drive(0, 0, 0, 18'h0, 16'h0);
    drive(1, 0, 0, 18'h0, 16'h0);
    b3.REQ0 = 0; b3.WE0 = 0; b3.ADDR0 = 0; b3.DIN0 = 0;
    b3.REQ1 = 0; b3.WE1 = 0; b3.ADDR1 = 0; b3.DIN1 = 0;
    @(negedge clk);
    chk("rst_csx", b1.SRAM_CSX, 1);
    chk("rst_oex", b1.SRAM_OEX, 1);
    chk("rst_wex", b1.SRAM_WEX, 1);
    chk("rst_doe", b1.SRAM_DOE, 0);
    chk("rst_ack", {b1.ACK1, b1.ACK0}, 0);
    chk("rst_dout0", b1.DOUT0, 0);
    chk("rst_dout1", b1.DOUT1, 0);
    chk("rst_addr", b1.SRAM_ADDR, 0);
    chk("rst_do", b1.SRAM_DO, 0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      drive(tv[i].port, 1, tv[i].we, tv[i].addr, tv[i].din);
      lat = 0; wl = 0; ol = 0; dh = 0; got = 0;
      for (int t = 1; t <= 12 && !got; t++) begin
        tick();
        if (t == 1) begin
          chk("tv_addr", b1.SRAM_ADDR, tv[i].addr);
          chk("tv_csx_setup", b1.SRAM_CSX, 0);
          if (tv[i].we) chk("tv_do", b1.SRAM_DO, tv[i].din);
        end
        wl += int'(!b1.SRAM_WEX);
        ol += int'(!b1.SRAM_OEX);
        dh += int'(b1.SRAM_DOE);
        if (tv[i].port ? b1.ACK1 : b1.ACK0) begin
          got = 1;
          lat = t;
        end
      end
      chk("tv_latency", lat, 2 + W1);
      chk("tv_wex_cycles", wl, tv[i].we ? W1 : 0);
      chk("tv_oex_cycles", ol, tv[i].we ? 0 : 1 + W1);
      chk("tv_doe_cycles", dh, tv[i].we ? 2 + W1 : 0);
      chk("tv_dout0", b1.DOUT0, tv[i].d0);
      chk("tv_dout1", b1.DOUT1, tv[i].d1);
      drive(tv[i].port, 0, 0, 18'h0, 16'h0);
      tick();
      chk("tv_idle_csx", b1.SRAM_CSX, 1);
      chk("tv_idle_ack", {b1.ACK1, b1.ACK0}, 0);
    end

    // held conflicting reads
    do_reset();
    drive(0, 1, 0, 18'h00003, 16'h0);
    drive(1, 1, 0, 18'h3FFFF, 16'h0);
    for (int t = 1; t <= 24; t++) begin
      tick();
      chk("conf_ack0", b1.ACK0,
          (t % 4 == 3) && (!RR || ((t / 4) % 2 == 0)));
      chk("conf_ack1", b1.ACK1,
          (t % 4 == 3) && RR && ((t / 4) % 2 == 1));
    end

    // reset in the middle of a write ACCESS
    do_reset();
    drive(1, 0, 0, 18'h0, 16'h0);
    drive(0, 1, 1, 18'h00040, 16'hC0DE);
    tick();
    tick();
    chk("mid_wex_access", b1.SRAM_WEX, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wex", b1.SRAM_WEX, 1);
    chk("mid_rst_csx", b1.SRAM_CSX, 1);
    chk("mid_rst_doe", b1.SRAM_DOE, 0);
    chk("mid_rst_ack", b1.ACK0, 0);
    tick();
    chk("mid_rst_noack", b1.ACK0, 0);
    rst_n = 1'b1;
    lat = 0; got = 0;
    for (int t = 1; t <= 12 && !got; t++) begin
      tick();
      if (b1.ACK0) begin
        got = 1;
        lat = t;
      end
    end
    chk("mid_restart_lat", lat, 2 + W1);
    drive(0, 0, 0, 18'h0, 16'h0);
    tick();

    // WAIT_CYCLES=3 read of the top word from port 1
    do_reset();
    mem3[32'h3FFFF] = 16'h1234;
    b3.REQ1 = 1; b3.WE1 = 0; b3.ADDR1 = 18'h3FFFF;
    lat = 0; got = 0; a0 = 0;
    for (int t = 1; t <= 15 && !got; t++) begin
      tick();
      a0 |= b3.ACK0;
      if (b3.ACK1) begin
        got = 1;
        lat = t;
      end
    end
    chk("w3_latency", lat, 2 + W3);
    chk("w3_dout1", b3.DOUT1, 16'h1234);
    chk("w3_dout0", b3.DOUT0, 16'h0000);
    chk("w3_no_ack0", a0, 0);
    b3.REQ1 = 0;
    tick();

    // randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 8; i++) begin
      refm[i] = 16'h7000 + 16'(i * 37);
      mem1[32'h100 + i] = refm[i];
    end
    ed[0] = 0; ed[1] = 0;
    e = 0; g_e = -10; ack_e = -10; nf = 1;
    last = 1; gp = 0; pend_rd = 0; pend_v = 0;
    rq[0] = 0; rq[1] = 0;
    for (int c = 0; c < 500; c++) begin
      a0 = (e == ack_e) && !gp;
      a1 = (e == ack_e) && gp;
      if (e == ack_e && pend_rd) ed[gp] = pend_v;
      chk("rnd_ack0", b1.ACK0, a0);
      chk("rnd_ack1", b1.ACK1, a1);
      chk("rnd_dout0", b1.DOUT0, ed[0]);
      chk("rnd_dout1", b1.DOUT1, ed[1]);
      if (!(e >= g_e && e <= ack_e))
        chk("rnd_idle_csx", b1.SRAM_CSX, 1);
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || (e == ack_e && gp == p)) begin
          rq[p] = ($urandom_range(0, 2) != 0);
          rw[p] = 1'($urandom_range(0, 1));
          ra[p] = 18'h100 + 18'($urandom_range(0, 7));
          r_d[p] = 16'($urandom);
        end else if (g_e <= e && e < ack_e && gp == p &&
                     $urandom_range(0, 1) == 1) begin
          rw[p] = ~rw[p];
          ra[p] = 18'($urandom);
          r_d[p] = 16'($urandom);
        end
        drive(p[0], rq[p], rw[p], ra[p], r_d[p]);
      end
      if (e + 1 == nf) begin
        if (rq[0] || rq[1]) begin
          gp = (rq[0] && rq[1]) ? (RR ? ~last : 1'b0) : rq[1];
          last = gp;
          g_e = e + 1;
          ack_e = g_e + 1 + W1;
          nf = g_e + 3 + W1;
          idx = int'(ra[gp]) - 'h100;
          if (rw[gp]) begin
            refm[idx] = r_d[gp];
            pend_rd = 0;
          end else begin
            pend_rd = 1;
            pend_v = refm[idx];
          end
        end else begin
          nf = e + 2;
        end
      end
      tick();
      e++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
